// File: rtl/instruction_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_pkg
//   Shared MIPS fetch constants: program text base, NOP encoding and the
//   sequential PC increment, plus the PC-update selector used by the fetch
//   unit.
// ----------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

   localparam logic [31:0] MIPS_TEXT_BASE = 32'h0040_0000;
   localparam logic [31:0] MIPS_NOP       = 32'h0000_0000;
   localparam int unsigned MIPS_PC_INCR   = 4;

   typedef enum logic [1:0] {
      PC_SEQ      = 2'd0,
      PC_HOLD     = 2'd1,
      PC_REDIRECT = 2'd2
   } pc_sel_e;

   // Redirect outranks stall; stall outranks sequential fetch.
   function automatic pc_sel_e pc_select(input logic redirect, input logic stall);
      if (redirect)   return PC_REDIRECT;
      else if (stall) return PC_HOLD;
      else            return PC_SEQ;
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_if
//   Bundle of the fetch unit's pipeline-control, ROM and IF/ID signals.
//   master : the fetch unit (drives PC, ProgramAddress, IF/ID, AddressError)
//   slave  : the surrounding pipeline / ROM (drives Stall, Redirect,
//            RedirectTarget, Instruction)
// ----------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  Stall;
   logic                  Redirect;
   logic [DATA_WIDTH-1:0] RedirectTarget;
   logic [DATA_WIDTH-1:0] Instruction;
   logic [DATA_WIDTH-1:0] ProgramAddress;
   logic [DATA_WIDTH-1:0] PC;
   logic [DATA_WIDTH-1:0] IFID_Instruction;
   logic [DATA_WIDTH-1:0] IFID_PCPlus4;
   logic                  IFID_Valid;
   logic                  AddressError;

   modport master (
      input  Stall, Redirect, RedirectTarget, Instruction,
      output ProgramAddress, PC, IFID_Instruction, IFID_PCPlus4,
             IFID_Valid, AddressError
   );

   modport slave (
      output Stall, Redirect, RedirectTarget, Instruction,
      input  ProgramAddress, PC, IFID_Instruction, IFID_PCPlus4,
             IFID_Valid, AddressError
   );
endinterface

// File: rtl/instruction_fetch_unit_ifid.sv
// ----------------------------------------------------------------------------
// ifid_pipeline_register
//   IF/ID pipeline register with load, hold and flush controls.
//   clk, reset     : clock, asynchronous active-low reset
//   load_i         : capture instr_i / pcplus4_i / valid_i
//   flush_i        : insert a bubble (valid=0, instr=NOP, pcplus4 holds);
//                    wins over load_i
//   neither        : hold
//   instr_o, pcplus4_o, valid_o : registered fields
// ----------------------------------------------------------------------------
module ifid_pipeline_register
   import instruction_fetch_unit_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_i,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] instr_i,
   input  logic [DATA_WIDTH-1:0] pcplus4_i,
   input  logic                  valid_i,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [DATA_WIDTH-1:0] pcplus4_o,
   output logic                  valid_o
);

   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic [DATA_WIDTH-1:0] pcplus4_q, pcplus4_d;
   logic                  valid_q, valid_d;

   always_comb begin
      instr_d   = instr_q;
      pcplus4_d = pcplus4_q;
      valid_d   = valid_q;
      if (flush_i) begin
         instr_d = DATA_WIDTH'(MIPS_NOP);
         valid_d = 1'b0;
      end else if (load_i) begin
         instr_d   = instr_i;
         pcplus4_d = pcplus4_i;
         valid_d   = valid_i;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_q   <= '0;
         pcplus4_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         instr_q   <= instr_d;
         pcplus4_q <= pcplus4_d;
         valid_q   <= valid_d;
      end
   end

   assign instr_o   = instr_q;
   assign pcplus4_o = pcplus4_q;
   assign valid_o   = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//   MIPS IF stage: PC register, ROM address generation, fetch legality check
//   and the IF/ID register. The program ROM is external and combinational.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   fe    : master modport of instruction_fetch_unit_if
//           in : Stall, Redirect, RedirectTarget, Instruction
//           out: ProgramAddress (PC - TEXT_BASE), PC, IFID_Instruction,
//                IFID_PCPlus4, IFID_Valid, AddressError (sticky)
// ----------------------------------------------------------------------------
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter int unsigned           MEMORY_DEPTH = 50,
   parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = DATA_WIDTH'(MIPS_TEXT_BASE)
) (
   input  logic                     clk,
   input  logic                     reset,
   instruction_fetch_unit_if.master fe
);

   localparam logic [DATA_WIDTH-1:0] ROM_BYTES = DATA_WIDTH'(MIPS_PC_INCR * MEMORY_DEPTH);
   localparam logic [DATA_WIDTH-1:0] PC_INCR   = DATA_WIDTH'(MIPS_PC_INCR);

   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic                  aerr_q, aerr_d;
   logic [DATA_WIDTH-1:0] prog_addr;
   logic [DATA_WIDTH-1:0] pc_plus4;
   logic                  fetch_legal;
   logic                  misaligned_tgt;
   pc_sel_e               pc_sel;

   assign prog_addr      = pc_q - TEXT_BASE;
   assign pc_plus4       = pc_q + PC_INCR;
   // The offset compare alone would accept PCs below TEXT_BASE that wrap to
   // small offsets only if ROM_BYTES spanned the wrap; the explicit lower
   // bound keeps the check independent of that.
   assign fetch_legal    = (pc_q >= TEXT_BASE) && (prog_addr < ROM_BYTES);
   assign misaligned_tgt = |fe.RedirectTarget[1:0];
   assign pc_sel         = pc_select(fe.Redirect, fe.Stall);

   always_comb begin
      pc_d   = pc_q;
      aerr_d = aerr_q;
      case (pc_sel)
         PC_REDIRECT: begin
            pc_d = {fe.RedirectTarget[DATA_WIDTH-1:2], 2'b00};
            if (misaligned_tgt) aerr_d = 1'b1;
         end
         PC_HOLD: pc_d = pc_q;
         default: begin
            pc_d = pc_plus4;
            if (!fetch_legal) aerr_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q   <= TEXT_BASE;
         aerr_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         aerr_q <= aerr_d;
      end
   end

   ifid_pipeline_register #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ifid (
      .clk       (clk),
      .reset     (reset),
      .load_i    (pc_sel == PC_SEQ),
      .flush_i   (pc_sel == PC_REDIRECT),
      .instr_i   (fe.Instruction),
      .pcplus4_i (pc_plus4),
      .valid_i   (fetch_legal),
      .instr_o   (fe.IFID_Instruction),
      .pcplus4_o (fe.IFID_PCPlus4),
      .valid_o   (fe.IFID_Valid)
   );

   assign fe.ProgramAddress = prog_addr;
   assign fe.PC             = pc_q;
   assign fe.AddressError   = aerr_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Directed and randomized stimulus for instruction_fetch_unit with an
//   external ROM (word n = n) and a behavioural model of the fetch stage.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

   localparam logic [31:0] BASE  = 32'h0040_0000;
   localparam int          DEPTH = 50;
   localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   logic [31:0] rom [DEPTH];

   instruction_fetch_unit_if #(.DATA_WIDTH(32)) bus ();

   instruction_fetch_unit #(
      .DATA_WIDTH   (32),
      .MEMORY_DEPTH (DEPTH),
      .TEXT_BASE    (BASE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .fe    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External combinational ROM, addressed by byte offset.
   always_comb begin
      if (bus.ProgramAddress < 32'(4 * DEPTH))
         bus.Instruction = rom[bus.ProgramAddress[31:2]];
      else
         bus.Instruction = JUNK;
   end

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc, m_ifi, m_ifp;
   logic        m_ifv, m_err;

   function automatic bit legal_pc(input logic [31:0] pc);
      longint off;
      off = longint'(pc) - longint'(BASE);
      return (off >= 0) && (off < 4 * DEPTH);
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] pc);
      longint off;
      off = longint'(pc) - longint'(BASE);
      if (off >= 0 && off < 4 * DEPTH) return rom[int'(off / 4)];
      return JUNK;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_pc  <= BASE;
         m_ifi <= 32'h0;
         m_ifp <= 32'h0;
         m_ifv <= 1'b0;
         m_err <= 1'b0;
      end else if (bus.Redirect) begin
         m_pc  <= bus.RedirectTarget - (bus.RedirectTarget % 4);
         m_ifi <= 32'h0;
         m_ifv <= 1'b0;
         if (bus.RedirectTarget % 4 != 0) m_err <= 1'b1;
      end else if (!bus.Stall) begin
         m_ifi <= word_at(m_pc);
         m_ifp <= m_pc + 32'd4;
         m_ifv <= legal_pc(m_pc);
         if (!legal_pc(m_pc)) m_err <= 1'b1;
         m_pc  <= m_pc + 32'd4;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("PC",               bus.PC,               m_pc);
      chk("ProgramAddress",   bus.ProgramAddress,   m_pc - BASE);
      chk("IFID_Instruction", bus.IFID_Instruction, m_ifi);
      chk("IFID_PCPlus4",     bus.IFID_PCPlus4,     m_ifp);
      chk("IFID_Valid",       32'(bus.IFID_Valid),  32'(m_ifv));
      chk("AddressError",     32'(bus.AddressError), 32'(m_err));
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_cmp = 0;
      n_bad = 0;
      for (int i = 0; i < DEPTH; i++) rom[i] = 32'(i);
      reset              = 1'b0;
      bus.Stall          = 1'b0;
      bus.Redirect       = 1'b0;
      bus.RedirectTarget = 32'h0;

      // Reset state
      #12;
      chk("rst_PC",    bus.PC,               BASE);
      chk("rst_IFI",   bus.IFID_Instruction, 32'h0);
      chk("rst_IFP",   bus.IFID_PCPlus4,     32'h0);
      chk("rst_IFV",   32'(bus.IFID_Valid),  32'h0);
      chk("rst_AERR",  32'(bus.AddressError), 32'h0);
      reset = 1'b1;

      // Sequential fetch
      step();
      chk("seq0_IFI", bus.IFID_Instruction, 32'd0);
      chk("seq0_IFV", 32'(bus.IFID_Valid),  32'd1);
      chk("seq0_IFP", bus.IFID_PCPlus4,     32'h0040_0004);
      chk("seq0_PC",  bus.PC,               32'h0040_0004);
      step();
      chk("seq1_IFI", bus.IFID_Instruction, 32'd1);
      chk("seq1_PC",  bus.PC,               32'h0040_0008);

      // Stall for three cycles
      bus.Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_PC",  bus.PC,               32'h0040_0008);
         chk("stall_IFI", bus.IFID_Instruction, 32'd1);
      end
      bus.Stall = 1'b0;
      step();
      chk("resume_IFI", bus.IFID_Instruction, 32'd2);
      chk("resume_PC",  bus.PC,               32'h0040_000C);

      // Redirect to 0x0040_0020
      bus.Redirect       = 1'b1;
      bus.RedirectTarget = 32'h0040_0020;
      step();
      chk("redir_PC",  bus.PC,               32'h0040_0020);
      chk("redir_IFV", 32'(bus.IFID_Valid),  32'd0);
      chk("redir_IFI", bus.IFID_Instruction, 32'd0);
      chk("redir_IFP", bus.IFID_PCPlus4,     32'h0040_000C);
      bus.Redirect = 1'b0;
      step();
      chk("tgt_IFI", bus.IFID_Instruction, 32'd8);
      chk("tgt_IFP", bus.IFID_PCPlus4,     32'h0040_0024);
      chk("tgt_IFV", 32'(bus.IFID_Valid),  32'd1);

      // Redirect and stall together
      bus.Redirect       = 1'b1;
      bus.Stall          = 1'b1;
      bus.RedirectTarget = 32'h0040_0010;
      step();
      chk("rs_PC",  bus.PC,              32'h0040_0010);
      chk("rs_IFV", 32'(bus.IFID_Valid), 32'd0);

      // Misaligned redirect target
      bus.Stall          = 1'b0;
      bus.RedirectTarget = 32'h0040_0022;
      step();
      chk("mis_PC",   bus.PC,                32'h0040_0020);
      chk("mis_AERR", 32'(bus.AddressError), 32'd1);
      bus.Redirect = 1'b0;

      // Asynchronous reset between edges
      #1 reset = 1'b0;
      #1;
      chk("arst_PC",   bus.PC,                BASE);
      chk("arst_AERR", 32'(bus.AddressError), 32'd0);
      chk("arst_IFV",  32'(bus.IFID_Valid),   32'd0);
      chk("arst_IFI",  bus.IFID_Instruction,  32'd0);
      #2 reset = 1'b1;
      step();
      chk("restart_IFI", bus.IFID_Instruction, 32'd0);
      chk("restart_IFV", 32'(bus.IFID_Valid),  32'd1);

      // Redirect to word 50 (out of range)
      bus.Redirect       = 1'b1;
      bus.RedirectTarget = 32'h0040_00C8;
      step();
      chk("oor_PC", bus.PC, 32'h0040_00C8);
      bus.Redirect = 1'b0;
      step();
      chk("oor_IFV",  32'(bus.IFID_Valid),   32'd0);
      chk("oor_AERR", 32'(bus.AddressError), 32'd1);
      step();
      step();
      chk("sticky_AERR", 32'(bus.AddressError), 32'd1);

      // Randomized phase
      #1 reset = 1'b0;
      #1 reset = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         step();
         if ($urandom_range(0, 149) == 0) begin
            reset = 1'b0;
            #2 reset = 1'b1;
         end
         bus.Stall    = ($urandom_range(0, 4) == 0);
         bus.Redirect = ($urandom_range(0, 6) == 0);
         case ($urandom_range(0, 19))
            0:       bus.RedirectTarget = $urandom;
            1:       bus.RedirectTarget = BASE + 32'($urandom_range(0, 60)) * 4 + 32'($urandom_range(1, 3));
            2:       bus.RedirectTarget = BASE - 32'd4;
            default: bus.RedirectTarget = BASE + 32'($urandom_range(0, 55)) * 4;
         endcase
      end
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
